usr_shift_reg: RTL and testbench

Parametrised universal shift register, the next generation of the fixed 4-bit 4:1-mux-per-bit shift register. WIDTH and count width are configurable. Besides single-step hold, shift-right, shift-left and parallel load, it adds an autonomous multi-shift burst with a busy/done handshake. Optionally it also supports rotate. It sits between the parallel datapath and serial links, where the parallel datapath loads or reads words and the serial links use sout_r/sout_l.

---
 rtl/usr_shift_reg.sv | 104 ++++++++++
 tb/tb_usr_shift_reg.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/usr_shift_reg.sv
// Parametrised universal shift register: hold / shift right / shift left / load,
// plus an autonomous multi-shift burst with busy/done. Define USR_ROTATE_EN for the rot port.
module usr_shift_reg #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNTW  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [1:0]       sel,
    input  logic             sin_r,
    input  logic             sin_l,
    input  logic [WIDTH-1:0] pin,
    input  logic             start,
    input  logic [CNTW-1:0]  count,
`ifdef USR_ROTATE_EN
    input  logic             rot,
`endif
    output logic [WIDTH-1:0] q,
    output logic             sout_r,
    output logic             sout_l,
    output logic             busy,
    output logic             done
);

    typedef enum logic {IDLE, BURST} state_t;

    state_t           state, state_d;
    logic [WIDTH-1:0] q_d;
    logic [CNTW-1:0]  rem, rem_d;
    logic             dir, dir_d;     // 0: shift right, 1: shift left
    logic             done_d;
    logic             ins_r, ins_l;
    logic [WIDTH-1:0] shr, shl;

`ifdef USR_ROTATE_EN
    assign ins_r = rot ? q[0]       : sin_r;
    assign ins_l = rot ? q[WIDTH-1] : sin_l;
`else
    assign ins_r = sin_r;
    assign ins_l = sin_l;
`endif

    assign shr    = {ins_r, q[WIDTH-1:1]};
    assign shl    = {q[WIDTH-2:0], ins_l};
    assign sout_r = q[0];
    assign sout_l = q[WIDTH-1];
    assign busy   = (state == BURST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            q     <= '0;
            rem   <= '0;
            dir   <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_d;
            q     <= q_d;
            rem   <= rem_d;
            dir   <= dir_d;
            done  <= done_d;
        end
    end

    always_comb begin
        state_d = state;
        q_d     = q;
        rem_d   = rem;
        dir_d   = dir;
        done_d  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    // Non-shift modes and zero counts complete immediately
                    if ((sel == 2'b01 || sel == 2'b10) && count != '0) begin
                        dir_d   = (sel == 2'b10);
                        rem_d   = count;
                        state_d = BURST;
                    end else begin
                        done_d = 1'b1;
                    end
                end else if (en) begin
                    case (sel)
                        2'b01:   q_d = shr;
                        2'b10:   q_d = shl;
                        2'b11:   q_d = pin;
                        default: q_d = q;
                    endcase
                end
            end
            BURST: begin
                q_d   = dir ? shl : shr;
                rem_d = rem - CNTW'(1);
                if (rem == CNTW'(1)) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_usr_shift_reg.sv
// Self-checking bench for usr_shift_reg (WIDTH=8, CNTW=4): directed steps then
// randomized cycles against an arithmetic reference model.
module tb_usr_shift_reg;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [1:0] sel;
    logic       sin_r;
    logic       sin_l;
    logic [7:0] pin;
    logic       start;
    logic [3:0] count;
    logic       rot;
    logic [7:0] q;
    logic       sout_r;
    logic       sout_l;
    logic       busy;
    logic       done;

    int vectors    = 0;
    int miscompares = 0;

    // reference model state
    int unsigned mq;
    int unsigned mrem;
    int unsigned mdir;
    bit          mdone;

    usr_shift_reg #(.WIDTH(8), .CNTW(4)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (en),
        .sel    (sel),
        .sin_r  (sin_r),
        .sin_l  (sin_l),
        .pin    (pin),
        .start  (start),
        .count  (count),
`ifdef USR_ROTATE_EN
        .rot    (rot),
`endif
        .q      (q),
        .sout_r (sout_r),
        .sout_l (sout_l),
        .busy   (busy),
        .done   (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit rot_on();
`ifdef USR_ROTATE_EN
        return rot;
`else
        return 1'b0;
`endif
    endfunction

    function automatic int unsigned shift_r(int unsigned v, bit s);
        int unsigned b = rot_on() ? (v & 1) : s;
        return (v >> 1) | (b << 7);
    endfunction

    function automatic int unsigned shift_l(int unsigned v, bit s);
        int unsigned b = rot_on() ? ((v >> 7) & 1) : s;
        return ((v << 1) & 8'hFF) | b;
    endfunction

    task automatic model_reset();
        mq = 0; mrem = 0; mdir = 0; mdone = 0;
    endtask

    task automatic model_edge();
        if (mrem > 0) begin
            mq    = (mdir == 2) ? shift_l(mq, sin_l) : shift_r(mq, sin_r);
            mrem  = mrem - 1;
            mdone = (mrem == 0);
        end else begin
            mdone = 0;
            if (start) begin
                if ((sel == 2'b01 || sel == 2'b10) && count != 0) begin
                    mrem = count;
                    mdir = sel;
                end else begin
                    mdone = 1;
                end
            end else if (en) begin
                case (sel)
                    2'b01: mq = shift_r(mq, sin_r);
                    2'b10: mq = shift_l(mq, sin_l);
                    2'b11: mq = pin;
                    default: ;
                endcase
            end
        end
    endtask

    task automatic check_model(input string tag);
        check({tag, ".q"},      32'(q),      mq);
        check({tag, ".busy"},   32'(busy),   32'(mrem > 0));
        check({tag, ".done"},   32'(done),   32'(mdone));
        check({tag, ".sout_r"}, 32'(sout_r), mq & 1);
        check({tag, ".sout_l"}, 32'(sout_l), (mq >> 7) & 1);
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_model(tag);
    endtask

    task automatic idle_inputs();
        en = 0; sel = 2'b00; start = 0; count = 0; sin_r = 0; sin_l = 0; rot = 0;
    endtask

    task automatic load(input logic [7:0] v);
        idle_inputs();
        en = 1; sel = 2'b11; pin = v;
        tick("load");
        en = 0;
    endtask

    task automatic async_reset(input string tag);
        #1 rst_n = 0;
        #1;
        model_reset();
        check({tag, ".q"},    32'(q),    0);
        check({tag, ".busy"}, 32'(busy), 0);
        check({tag, ".done"}, 32'(done), 0);
        #1 rst_n = 1;
    endtask

    initial begin
        rst_n = 0; pin = 0;
        idle_inputs();
        model_reset();
        #3;
        check("por.q",    32'(q),    0);
        check("por.busy", 32'(busy), 0);
        check("por.done", 32'(done), 0);
        #4 rst_n = 1;

        // single steps
        load(8'hA5);
        check("step.load", 32'(q), 32'h A5);
        en = 1; sel = 2'b01; sin_r = 1;
        tick("step.shr");
        check("step.shr_val", 32'(q), 32'h D2);
        sel = 2'b10; sin_l = 0;
        tick("step.shl");
        check("step.shl_val", 32'(q), 32'h A4);
        sel = 2'b00;
        tick("step.hold");
        en = 0;
        for (int s = 0; s < 4; s++) begin
            sel = 2'(s); pin = 8'h3C; sin_r = 1; sin_l = 1;
            tick("step.en0");
        end
        check("step.en0_val", 32'(q), 32'h A4);

        // burst of 3 left shifts, with a second start dropped
        load(8'h81);
        sel = 2'b10; sin_l = 0; count = 4'd3; start = 1;
        tick("burst.k");
        check("burst.k_busy", 32'(busy), 1);
        sel = 2'b11; count = 4'd7; pin = 8'hFF;
        tick("burst.k1");
        check("burst.k1_q", 32'(q), 32'h 02);
        start = 0;
        tick("burst.k2");
        check("burst.k2_q", 32'(q), 32'h 04);
        tick("burst.k3");
        check("burst.k3_q", 32'(q), 32'h 08);
        check("burst.k3_done", 32'(done), 1);
        check("burst.k3_busy", 32'(busy), 0);
        tick("burst.k4");
        check("burst.k4_done", 32'(done), 0);

        // degenerate start
        idle_inputs();
        sel = 2'b01; count = 0; start = 1;
        tick("degen.k");
        check("degen.done", 32'(done), 1);
        start = 0;
        tick("degen.k1");
        sel = 2'b11; count = 4'd5; start = 1;
        tick("degen.load_sel");
        start = 0;
        tick("degen.after");

        // reset between edges while busy with q=0x5A
        load(8'h5A);
        sel = 2'b01; count = 4'd5; start = 1;
        tick("rst.k");
        start = 0;
        async_reset("rst.busy");
        tick("rst.after");

        // abort after second shift of a count=5 burst
        load(8'hF0);
        sel = 2'b01; sin_r = 1; count = 4'd5; start = 1;
        tick("abort.k");
        start = 0;
        tick("abort.s1");
        tick("abort.s2");
        async_reset("abort");
        for (int i = 0; i < 4; i++) tick("abort.nodone");

`ifdef USR_ROTATE_EN
        load(8'h81);
        en = 1; rot = 1; sel = 2'b01; sin_r = 0;
        tick("rot.r");
        check("rot.r_val", 32'(q), 32'h C0);
        sel = 2'b10; sin_l = 0;
        tick("rot.l");
        check("rot.l_val", 32'(q), 32'h 81);
        load(8'h6B);
        rot = 1; sel = 2'b01; count = 4'd8; start = 1;
        tick("rot.burst_k");
        start = 0;
        for (int i = 0; i < 8; i++) tick("rot.burst");
        check("rot.burst_val", 32'(q), 32'h 6B);
`endif

        // randomized cycles
        for (int i = 0; i < 500; i++) begin
            en    = 1'($urandom);
            sel   = 2'($urandom);
            sin_r = 1'($urandom);
            sin_l = 1'($urandom);
            pin   = 8'($urandom);
            start = ($urandom_range(0, 5) == 0);
            count = 4'($urandom);
            rot   = 1'($urandom);
            if ($urandom_range(0, 60) == 0) async_reset("rand.rst");
            tick("rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
